// File: rtl/pipe_ctrl.sv
// Purpose : D-stage hazard/stall control plus the multiply/divide busy tracker.
// Latency : stall/flush_DE/md_busy are combinational; md_done, md_state and stall_cnt are registered.
// Backpr. : stall holds PC and F/D while flush_DE bubbles D/E; E/M is never held by this block.
//
// Ports:
//   clk, reset               - single clock; asynchronous active-high reset
//   D_rs/D_rt, *_tuse        - D-stage sources and the cycles until each is needed (3 = unused)
//   D_md                     - D instruction touches the MD unit
//   E_/M_regaddr, _regWrite,
//   E_/M_tnew                - producer destinations and cycles until their results exist
//   E_mdstart, E_mdop        - E instruction launches mult (0) or div (1)
//   stall, flush_DE          - hold front end / inject D/E bubble
//   md_busy, md_done,
//   md_state                 - MD unit occupancy, completion pulse, FSM state
//   stall_cnt                - saturating count of stalled cycles since reset
module pipe_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_md,
    input  logic [4:0]  E_regaddr,
    input  logic [4:0]  M_regaddr,
    input  logic        E_regWrite,
    input  logic        M_regWrite,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        E_mdstart,
    input  logic        E_mdop,
    output logic        stall,
    output logic        flush_DE,
    output logic        md_busy,
    output logic        md_done,
    output logic [1:0]  md_state,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MULT = 2'b01,
        ST_DIV  = 2'b10
    } md_state_t;

    md_state_t   state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic        md_done_q, md_done_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic rs_hz, rt_hz, data_stall, md_stall;

    // A source stalls only if a producer will still be computing when the
    // consumer needs the value; register 0 is hardwired and never hazards.
    assign rs_hz = (D_rs != 5'd0) &&
                   (((D_rs == E_regaddr) && E_regWrite && (E_tnew > D_rs_tuse)) ||
                    ((D_rs == M_regaddr) && M_regWrite && (M_tnew > D_rs_tuse)));
    assign rt_hz = (D_rt != 5'd0) &&
                   (((D_rt == E_regaddr) && E_regWrite && (E_tnew > D_rt_tuse)) ||
                    ((D_rt == M_regaddr) && M_regWrite && (M_tnew > D_rt_tuse)));

    assign data_stall = rs_hz | rt_hz;

    // A start seen in IDLE counts as busy already, so an MD instruction
    // sitting in D behind it is held in that same cycle.
    assign md_busy  = (E_mdstart && (state_q == ST_IDLE)) || (state_q != ST_IDLE);
    assign md_stall = D_md & md_busy;

    assign stall     = data_stall | md_stall;
    assign flush_DE  = stall;
    assign md_done   = md_done_q;
    assign md_state  = state_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (E_mdstart) begin
                    state_d  = E_mdop ? ST_DIV : ST_MULT;
                    md_cnt_d = E_mdop ? 4'(DIV_CYC) : 4'(MULT_CYC);
                end
            end
            ST_MULT, ST_DIV: begin
                // Starts arriving while busy are ignored: no reload here.
                if (md_cnt_q == 4'd1) begin
                    state_d   = ST_IDLE;
                    md_cnt_d  = 4'd0;
                    md_done_d = 1'b1;
                end else begin
                    md_cnt_d = md_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                md_cnt_d = 4'd0;
            end
        endcase
    end

    // Simultaneous data and MD stalls are one stalled cycle, hence one count.
    assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                   : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            md_cnt_q    <= 4'd0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_regaddr, M_regaddr;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_md, E_regWrite, M_regWrite, E_mdstart, E_mdop;
    logic        stall, flush_DE, md_busy, md_done;
    logic [1:0]  md_state;
    logic [31:0] stall_cnt;

    pipe_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_tuse  (D_rs_tuse),
        .D_rt_tuse  (D_rt_tuse),
        .D_md       (D_md),
        .E_regaddr  (E_regaddr),
        .M_regaddr  (M_regaddr),
        .E_regWrite (E_regWrite),
        .M_regWrite (M_regWrite),
        .E_tnew     (E_tnew),
        .M_tnew     (M_tnew),
        .E_mdstart  (E_mdstart),
        .E_mdop     (E_mdop),
        .stall      (stall),
        .flush_DE   (flush_DE),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .md_state   (md_state),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic clr_haz();
        D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        E_regaddr = 5'd0; M_regaddr = 5'd0; E_regWrite = 1'b0; M_regWrite = 1'b0;
        E_tnew = 2'd0; M_tnew = 2'd0;
    endtask

    task automatic haz_check(input string tag, input logic exp_stall);
        sb_push(tag, 32'(exp_stall));
        sb_push({tag, "_flush"}, 32'(exp_stall));
        #1;
        sb_check(32'(stall));
        sb_check(32'(flush_DE));
        clr_haz();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_haz();
        D_md = 1'b0; E_mdstart = 1'b0; E_mdop = 1'b0;

        // Reset state
        sb_push("rst_state", 0); sb_push("rst_busy", 0); sb_push("rst_done", 0);
        sb_push("rst_cnt", 0);   sb_push("rst_stall", 0);
        #1;
        sb_check(32'(md_state)); sb_check(32'(md_busy)); sb_check(32'(md_done));
        sb_check(stall_cnt);     sb_check(32'(stall));
        @(negedge clk);
        reset = 1'b0;

        // Combinational hazards; cleared before each posedge so none is counted
        @(negedge clk);
        E_regaddr = 5'd8; E_regWrite = 1'b1; E_tnew = 2'd2; D_rs = 5'd8; D_rs_tuse = 2'd1;
        haz_check("load_use_rs", 1'b1);
        E_regaddr = 5'd0; E_regWrite = 1'b1; E_tnew = 2'd2; D_rs = 5'd0; D_rs_tuse = 2'd1;
        haz_check("zero_reg", 1'b0);
        M_regaddr = 5'd9; M_regWrite = 1'b1; M_tnew = 2'd0; D_rt = 5'd9; D_rt_tuse = 2'd0;
        haz_check("fwd_rt_m", 1'b0);
        @(negedge clk);
        M_regaddr = 5'd9; M_regWrite = 1'b1; M_tnew = 2'd1; D_rt = 5'd9; D_rt_tuse = 2'd0;
        haz_check("m_rt_stall", 1'b1);
        E_regaddr = 5'd4; E_regWrite = 1'b1; E_tnew = 2'd1; D_rt = 5'd4; D_rt_tuse = 2'd1;
        haz_check("tnew_eq_tuse", 1'b0);
        E_regaddr = 5'd4; E_regWrite = 1'b0; E_tnew = 2'd2; D_rs = 5'd4; D_rs_tuse = 2'd0;
        haz_check("no_regwrite", 1'b0);
        @(negedge clk);
        E_regaddr = 5'd7; E_regWrite = 1'b1; E_tnew = 2'd2; D_rs = 5'd7; D_rs_tuse = 2'd3;
        haz_check("unused_src", 1'b0);

        // Mult: busy cycles 0..5, done in 6, D_md stalls in 0..5
        @(negedge clk);
        E_mdstart = 1'b1; E_mdop = 1'b0; D_md = 1'b1;
        sb_push("mult_c0_busy", 1); sb_push("mult_c0_stall", 1);
        #1;
        sb_check(32'(md_busy)); sb_check(32'(stall));
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            E_mdstart = 1'b0;
            if (k == 7) D_md = 1'b0;
            sb_push($sformatf("mult_c%0d_busy", k),  32'(k <= 5));
            sb_push($sformatf("mult_c%0d_state", k), (k <= 5) ? 32'd1 : 32'd0);
            sb_push($sformatf("mult_c%0d_done", k),  32'(k == 6));
            sb_push($sformatf("mult_c%0d_stall", k), 32'(k <= 5));
            #1;
            sb_check(32'(md_busy)); sb_check(32'(md_state));
            sb_check(32'(md_done)); sb_check(32'(stall));
        end
        sb_push("mult_stall_cnt", 6);
        sb_check(stall_cnt);

        // Div with an ignored second start in cycle 3
        @(negedge clk);
        E_mdstart = 1'b1; E_mdop = 1'b1;
        sb_push("div_c0_busy", 1);
        #1;
        sb_check(32'(md_busy));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            E_mdstart = (k == 3);
            E_mdop = 1'b0;
            sb_push($sformatf("div_c%0d_state", k), (k <= 10) ? 32'd2 : 32'd0);
            sb_push($sformatf("div_c%0d_done", k),  32'(k == 11));
            sb_push($sformatf("div_c%0d_busy", k),  32'(k <= 10));
            #1;
            sb_check(32'(md_state)); sb_check(32'(md_done)); sb_check(32'(md_busy));
        end
        E_mdstart = 1'b0;
        sb_push("div_stall_cnt", 6);
        sb_check(stall_cnt);

        // Async reset at div cycle 4, between edges
        @(negedge clk);
        E_mdstart = 1'b1; E_mdop = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            E_mdstart = 1'b0;
        end
        sb_push("arst_pre_state", 2);
        #1;
        sb_check(32'(md_state));
        reset = 1'b1;
        sb_push("arst_state", 0); sb_push("arst_busy", 0);
        sb_push("arst_done", 0);  sb_push("arst_cnt", 0);
        #1;
        sb_check(32'(md_state)); sb_check(32'(md_busy));
        sb_check(32'(md_done));  sb_check(stall_cnt);
        E_mdstart = 1'b1;
        sb_push("arst_busy_start", 1);
        #1;
        sb_check(32'(md_busy));
        E_mdstart = 1'b0;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            sb_push($sformatf("post_arst_c%0d_done", k), 0);
            sb_push($sformatf("post_arst_c%0d_state", k), 0);
            #1;
            sb_check(32'(md_done)); sb_check(32'(md_state));
        end

        // Saturation of stall_cnt under a held data stall
        @(negedge clk);
        E_regaddr = 5'd8; E_regWrite = 1'b1; E_tnew = 2'd2; D_rs = 5'd8; D_rs_tuse = 2'd1;
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt_q;
        sb_push("sat_stall", 1); sb_push("sat_c0_cnt", 32'hFFFF_FFFD);
        sb_check(32'(stall)); sb_check(stall_cnt);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            sb_push($sformatf("sat_c%0d_cnt", k), (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            #1;
            sb_check(stall_cnt);
        end
        clr_haz();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
